// File: rtl/ircam_readout_timing.sv
// IR camera sensor readout timing: integration, row readout, h/v blanking, paced by div_in ticks.
// Optional define IRCAM_FRAME_CNT_EN adds a 16-bit wrapping frame counter output (frame_cnt).
module ircam_readout_timing #(
    parameter int COLS   = 32,
    parameter int ROWS   = 24,
    parameter int HBLANK = 4,
    parameter int VBLANK = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     div_in,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     cont,
    input  logic [15:0]              int_time,
    output logic                     busy,
    output logic                     frame_start,
    output logic                     int_active,
    output logic                     line_valid,
    output logic                     pix_valid,
    output logic [$clog2(COLS)-1:0]  pix_col,
    output logic [$clog2(ROWS)-1:0]  pix_row,
    output logic                     frame_done,
`ifdef IRCAM_FRAME_CNT_EN
    output logic [15:0]              frame_cnt,
`endif
    output logic [2:0]               state_dbg
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int HW = $clog2(HBLANK + 1);
    localparam int VW = $clog2(VBLANK + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [HW-1:0] HB_LOAD  = HW'(HBLANK);
    localparam logic [VW-1:0] VB_LOAD  = VW'(VBLANK);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INTEG   = 3'd1,
        ST_ROW     = 3'd2,
        ST_HBLANK  = 3'd3,
        ST_VBLANK  = 3'd4
    } state_t;

    state_t        state;
    logic          s1, s2, s3;
    logic          tick;
    logic          start_pend, stop_pend;
    logic [15:0]   int_cnt;
    logic [15:0]   int_load;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;

    // div_in is asynchronous to clk: two flops to settle, a third to find the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= div_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick      = s2 & ~s3;
    assign int_load  = (int_time == 16'd0) ? 16'd1 : int_time;
    assign state_dbg = state;

    // start/stop are levels sampled every clk; start only counts while idle, stop only
    // marks the running frame to be the last one and never cuts it short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            start_pend  <= 1'b0;
            stop_pend   <= 1'b0;
            int_cnt     <= '0;
            col         <= '0;
            row         <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            int_active  <= 1'b0;
            line_valid  <= 1'b0;
            pix_valid   <= 1'b0;
            pix_col     <= '0;
            pix_row     <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            pix_valid   <= 1'b0;

            if (state == ST_IDLE) begin
                if (stop) begin
                    start_pend <= 1'b0;
                    stop_pend  <= 1'b0;
                end else if (start) begin
                    start_pend <= 1'b1;
                end
            end else if (stop) begin
                stop_pend <= 1'b1;
            end

            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (start_pend && !stop) begin
                            state       <= ST_INTEG;
                            int_cnt     <= int_load;
                            frame_start <= 1'b1;
                            start_pend  <= 1'b0;
                            busy        <= 1'b1;
                            int_active  <= 1'b1;
                        end
                    end
                    ST_INTEG: begin
                        if (int_cnt == 16'd1) begin
                            state      <= ST_ROW;
                            col        <= '0;
                            row        <= '0;
                            int_active <= 1'b0;
                            line_valid <= 1'b1;
                        end else begin
                            int_cnt <= int_cnt - 16'd1;
                        end
                    end
                    ST_ROW: begin
                        pix_valid <= 1'b1;
                        pix_col   <= col;
                        pix_row   <= row;
                        if (col == COL_LAST) begin
                            state      <= ST_HBLANK;
                            hcnt       <= HB_LOAD;
                            col        <= '0;
                            line_valid <= 1'b0;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                    ST_HBLANK: begin
                        if (hcnt == HW'(1)) begin
                            if (row == ROW_LAST) begin
                                state <= ST_VBLANK;
                                vcnt  <= VB_LOAD;
                                row   <= '0;
                            end else begin
                                state      <= ST_ROW;
                                row        <= row + 1'b1;
                                line_valid <= 1'b1;
                            end
                        end else begin
                            hcnt <= hcnt - 1'b1;
                        end
                    end
                    ST_VBLANK: begin
                        if (vcnt == VW'(1)) begin
                            frame_done <= 1'b1;
                            if (cont && !stop_pend && !stop) begin
                                state       <= ST_INTEG;
                                int_cnt     <= int_load;
                                frame_start <= 1'b1;
                                int_active  <= 1'b1;
                            end else begin
                                state      <= ST_IDLE;
                                busy       <= 1'b0;
                                stop_pend  <= 1'b0;
                                start_pend <= 1'b0;
                            end
                        end else begin
                            vcnt <= vcnt - 1'b1;
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        int_active <= 1'b0;
                        line_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef IRCAM_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
